cp2_fetch_queue_stage: RTL and testbench

//  Parametrised successor to the single-register CP2 fetch stage. Buffers fetched

---
 rtl/cp2_fetch_queue_stage.sv | 117 +++++++++++
 tb/tb_cp2_fetch_queue_stage.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cp2_fetch_queue_stage.sv
// DEPTH-entry show-ahead instruction queue between the fetch source and decode.
// Each accepted word is tagged with a monotonic sequence number; flush empties the queue.
module cp2_fetch_queue_stage #(
  parameter int INS_W = 32,
  parameter int DEPTH = 4,
  parameter int SEQ_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     irenable,
  input  logic [INS_W-1:0]         ir,
  output logic                     ir_ready,
  input  logic                     flush,
  input  logic                     decode_ready,
  output logic                     decode_en,
  output logic [INS_W-1:0]         fetch_instruction,
  output logic [SEQ_W-1:0]         fetch_seq,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [INS_W-1:0] ins;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  entry_t           head_q, head_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             push, pop;

  // Handshake outputs depend only on registered state, so decode_ready never
  // reaches ir_ready combinationally.
  assign ir_ready          = (count_q != FULL_CNT);
  assign decode_en         = (count_q != '0);
  assign queue_count       = count_q;
  assign fetch_instruction = head_q.ins;
  assign fetch_seq         = head_q.seq;

  // A flushed cycle accepts nothing, so no sequence tag is consumed by a dropped push.
  assign push = irenable & ir_ready & ~flush;
  assign pop  = decode_en & decode_ready & ~flush;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned
    // (which would infer a latch); blocking '=' is correct inside always_comb.
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    seq_d    = seq_q;
    head_d   = head_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{seq: seq_q, ins: ir};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        seq_d           = seq_q + SEQ_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      // Head register tracks the next head; reading mem_d covers a push into an
      // empty queue. When the queue drains the last head value is simply held.
      if (count_d != '0) begin
        head_d = mem_d[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the storage array is reset here only because a defined all-zero
      // power-on state is required; a plain FIFO RAM would normally skip this.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      head_q   <= head_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
    end
  end

  // Occupancy bookkeeping must stay consistent with the pointer distance.
  a_count_range : assert property (@(posedge clk) disable iff (!rst)
    count_q <= FULL_CNT);
  a_ptr_distance : assert property (@(posedge clk) disable iff (!rst)
    (count_q == FULL_CNT) || (PTR_W'(wr_ptr_q - rd_ptr_q) == count_q[PTR_W-1:0]));

endmodule

// File: tb/tb_cp2_fetch_queue_stage.sv
// Directed bench for cp2_fetch_queue_stage: vector table plus hand sequences for
// mid-stream reset and sequence-tag / pointer wrap.
module tb_cp2_fetch_queue_stage;

  logic        clk;
  logic        rst;
  logic        irenable;
  logic [31:0] ir;
  logic        ir_ready;
  logic        flush;
  logic        decode_ready;
  logic        decode_en;
  logic [31:0] fetch_instruction;
  logic [7:0]  fetch_seq;
  logic [2:0]  queue_count;

  int total = 0;
  int bad   = 0;

  cp2_fetch_queue_stage #(.INS_W(32), .DEPTH(4), .SEQ_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .irenable          (irenable),
    .ir                (ir),
    .ir_ready          (ir_ready),
    .flush             (flush),
    .decode_ready      (decode_ready),
    .decode_en         (decode_en),
    .fetch_instruction (fetch_instruction),
    .fetch_seq         (fetch_seq),
    .queue_count       (queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        ie;
    logic [31:0] ir;
    logic        dr;
    logic        de;
    logic [31:0] ins;
    logic [7:0]  seq;
    logic [2:0]  cnt;
    logic        rdy;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic de, input logic [31:0] ins,
                            input logic [7:0] seq, input logic [2:0] cnt, input logic rdy);
    check({tag, ".decode_en"},   64'(decode_en),         64'(de));
    check({tag, ".fetch_ins"},   64'(fetch_instruction), 64'(ins));
    check({tag, ".fetch_seq"},   64'(fetch_seq),         64'(seq));
    check({tag, ".queue_count"}, 64'(queue_count),       64'(cnt));
    check({tag, ".ir_ready"},    64'(ir_ready),          64'(rdy));
  endtask

  task automatic add(input logic fl, input logic ie, input logic [31:0] w, input logic dr,
                     input logic de, input logic [31:0] ins, input logic [7:0] seq,
                     input logic [2:0] cnt, input logic rdy);
    vec_t v;
    v.fl = fl; v.ie = ie; v.ir = w; v.dr = dr;
    v.de = de; v.ins = ins; v.seq = seq; v.cnt = cnt; v.rdy = rdy;
    vq.push_back(v);
  endtask

  // Apply inputs for one rising edge, then let outputs settle before the caller samples.
  task automatic step(input logic fl, input logic ie, input logic [31:0] w, input logic dr);
    flush = fl; irenable = ie; ir = w; decode_ready = dr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; irenable = 1'b0; ir = '0; flush = 1'b0; decode_ready = 1'b0;

    //   fl ie  ir            dr   de  ins           seq   cnt rdy
    // back-to-back pushes with decode always ready
    add(0, 1, 32'hA5A5_0001, 1,   1, 32'hA5A5_0001, 8'd0, 3'd1, 1);
    add(0, 1, 32'hA5A5_0002, 1,   1, 32'hA5A5_0002, 8'd1, 3'd1, 1);
    add(0, 1, 32'hA5A5_0003, 1,   1, 32'hA5A5_0003, 8'd2, 3'd1, 1);
    add(0, 0, 32'h0,         1,   0, 32'hA5A5_0003, 8'd2, 3'd0, 1);
    add(0, 0, 32'h0,         1,   0, 32'hA5A5_0003, 8'd2, 3'd0, 1);
    // fill with decode stalled; fifth word held off
    add(0, 1, 32'hB000_0001, 0,   1, 32'hB000_0001, 8'd3, 3'd1, 1);
    add(0, 1, 32'hB000_0002, 0,   1, 32'hB000_0001, 8'd3, 3'd2, 1);
    add(0, 1, 32'hB000_0003, 0,   1, 32'hB000_0001, 8'd3, 3'd3, 1);
    add(0, 1, 32'hB000_0004, 0,   1, 32'hB000_0001, 8'd3, 3'd4, 0);
    add(0, 1, 32'hB000_0005, 0,   1, 32'hB000_0001, 8'd3, 3'd4, 0);
    // full plus pop: no push that cycle
    add(0, 1, 32'hB000_0005, 1,   1, 32'hB000_0002, 8'd4, 3'd3, 1);
    add(0, 1, 32'hB000_0005, 0,   1, 32'hB000_0002, 8'd4, 3'd4, 0);
    add(0, 0, 32'h0,         1,   1, 32'hB000_0003, 8'd5, 3'd3, 1);
    add(0, 0, 32'h0,         1,   1, 32'hB000_0004, 8'd6, 3'd2, 1);
    // simultaneous push and pop at count 2
    add(0, 1, 32'hC000_0001, 1,   1, 32'hB000_0005, 8'd7, 3'd2, 1);
    add(0, 1, 32'hC000_0002, 0,   1, 32'hB000_0005, 8'd7, 3'd3, 1);
    // flush at count 3 with push and pop offered: all discarded, head value held
    add(1, 1, 32'hC000_0003, 1,   0, 32'hB000_0005, 8'd7, 3'd0, 1);
    // next accepted word carries last accepted tag + 1
    add(0, 1, 32'hD000_0001, 0,   1, 32'hD000_0001, 8'd10, 3'd1, 1);
    add(0, 0, 32'h0,         1,   0, 32'hD000_0001, 8'd10, 3'd0, 1);

    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 32'h0, 8'h0, 3'd0, 1'b1);
    rst = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].fl, vq[i].ie, vq[i].ir, vq[i].dr);
      check_outs($sformatf("vec%0d", i), vq[i].de, vq[i].ins, vq[i].seq, vq[i].cnt, vq[i].rdy);
    end

    // Asynchronous reset between edges with words queued.
    step(0, 1, 32'hE000_0001, 0);
    step(0, 1, 32'hE000_0002, 0);
    check("pre_reset.queue_count", 64'(queue_count), 64'd2);
    irenable = 1'b0; decode_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_outs("async_reset", 1'b0, 32'h0, 8'h0, 3'd0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(0, 1, 32'hE000_0003, 0);
    check_outs("post_reset", 1'b1, 32'hE000_0003, 8'd0, 3'd1, 1'b1);
    step(0, 0, 32'h0, 1);
    check_outs("post_reset_drain", 1'b0, 32'hE000_0003, 8'd0, 3'd0, 1'b1);

    // Streaming push/pop pairs: tag wraps past 255, pointers wrap many times.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] exp_seq;
      exp_seq = 8'(i + 1);
      step(0, 1, 32'hF000_0000 + 32'(i), 1);
      check($sformatf("wrap%0d.ins", i), 64'(fetch_instruction), 64'(32'hF000_0000 + 32'(i)));
      check($sformatf("wrap%0d.seq", i), 64'(fetch_seq), 64'(exp_seq));
      check($sformatf("wrap%0d.cnt", i), 64'(queue_count), 64'd1);
    end
    step(0, 0, 32'h0, 1);
    check_outs("wrap_drain", 1'b0, 32'hF000_0000 + 32'd299, 8'd44, 3'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
